// File: rtl/alu_op_sequencer.sv
// Valid/ready command front-end for the 8-bit ALU: registers operands onto the ALU, captures Y/Cout plus flags.
// Optional feature: define ALU_ACC_EN to add a result accumulator selectable as operand A via cmd_use_acc.
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_sel,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic             res_c,
    output logic             res_z,
    output logic             res_n,
    output logic             res_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic accept;
    logic capture;
    logic sel_illegal;
    logic sel_arith;
    logic [WIDTH-1:0] load_a;

    // Ready is masked by reset so nothing can be accepted on the reset edge.
    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign sel_illegal = alu_sel[2] & alu_sel[1];
    assign sel_arith   = (alu_sel[2:1] == 2'b00);

`ifdef ALU_ACC_EN
    logic [WIDTH-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (capture) begin
            acc <= sel_illegal ? '0 : alu_y;
        end
    end

    assign load_a = cmd_use_acc ? acc : cmd_a;
`else
    assign load_a = cmd_a;
`endif

    // ALU operand registers only move on acceptance; the ALU settles during EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (accept) begin
            alu_a   <= load_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_y   <= '0;
            res_c   <= 1'b0;
            res_z   <= 1'b0;
            res_n   <= 1'b0;
            res_err <= 1'b0;
        end else if (capture) begin
            res_y   <= sel_illegal ? '0 : alu_y;
            res_c   <= sel_arith & alu_cout;
            res_z   <= !sel_illegal && (alu_y == '0);
            res_n   <= !sel_illegal && alu_y[WIDTH-1];
            res_err <= sel_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
        end else if ((state == DONE) && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // A presented command must be fully defined, including the accumulator select.
    assert property (@(posedge clk) disable iff (rst)
        cmd_valid |-> !$isunknown({cmd_a, cmd_b, cmd_sel, cmd_use_acc}));

    assert property (@(posedge clk) disable iff (rst)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_y) && $stable(res_err)));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: bench-side ALU model, randomized commands, directed test-plan cases.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       cmd_use_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_y;
    logic       alu_cout;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_y;
    logic       res_c;
    logic       res_z;
    logic       res_n;
    logic       res_err;

    typedef struct packed {
        logic [7:0] y;
        logic       c;
        logic       z;
        logic       n;
        logic       err;
    } res_t;

    res_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    int   accModel = 0;
    logic readyManual = 1'b1;

    alu_op_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_c(res_c), .res_z(res_z), .res_n(res_n), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Stand-in for alu_top_8bit; junk carry on non-arith ops and junk Y on illegal ops
    always_comb begin
        alu_y    = 8'h00;
        alu_cout = 1'b1;
        case (alu_sel)
            3'b000: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            3'b010: alu_y = alu_a & alu_b;
            3'b011: alu_y = alu_a | alu_b;
            3'b100: alu_y = alu_a << alu_b[2:0];
            3'b101: alu_y = $signed(alu_a) >>> alu_b[2:0];
            default: alu_y = alu_a ^ alu_b ^ 8'h5A;
        endcase
    end

    function automatic res_t refModel(int a, int b, int sel);
        res_t e;
        int   r;
        int   sh;
        e  = '0;
        r  = 0;
        sh = b % 8;
        case (sel)
            0: begin r = a + b; e.c = (r > 255); end
            1: begin r = a - b; e.c = (a >= b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a * (1 << sh);
            5: begin r = (a >= 128) ? a - 256 : a; r = r >>> sh; end
            default: begin e.err = 1'b1; r = 0; end
        endcase
        e.y = 8'(r & 255);
        e.z = !e.err && (e.y == 8'd0);
        e.n = e.y[7];
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!readyManual) res_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops on the first cycle of each result, then checks it holds
    res_t snap;
    logic prevValid = 1'b0;
    always @(negedge clk) begin
        if (res_valid) begin
            if (!prevValid) begin
                snap = {res_y, res_c, res_z, res_n, res_err};
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 64'(snap), 64'hFFFF);
                end else begin
                    checkOutput("result", 64'(snap), 64'(expQ.pop_front()));
                end
            end else begin
                checkOutput("result_hold", 64'({res_y, res_c, res_z, res_n, res_err}), 64'(snap));
            end
        end
        prevValid = res_valid;
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) checkOutput("idle_timeout", 64'(cmd_ready), 64'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] sel, input logic useAcc);
        int   n = 0;
        int   aEff;
        res_t e;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_use_acc = useAcc; cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        aEff = a;
`ifdef ALU_ACC_EN
        if (useAcc) aEff = accModel;
`endif
        e = refModel(aEff, b, sel);
        expQ.push_back(e);
        accModel = e.y;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 3'($urandom); cmd_use_acc = 1'($urandom);
        @(negedge clk);
        checkOutput("alu_a", 64'(alu_a), 64'(aEff));
        checkOutput("alu_b", 64'(alu_b), 64'(b));
        checkOutput("alu_sel", 64'(alu_sel), 64'(sel));
        checkOutput("exec_no_valid", 64'(res_valid), 64'd0);
        checkOutput("exec_not_ready", 64'(cmd_ready), 64'd0);
    endtask

    task automatic checkLatency();
        @(negedge clk);
        checkOutput("latency_res_valid", 64'(res_valid), 64'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_alu"}, 64'({alu_a, alu_b, alu_sel}), 64'd0);
        checkOutput({tag, "_res"}, 64'({res_valid, res_y, res_c, res_z, res_n, res_err}), 64'd0);
        checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_sel = 3'd0;
        cmd_use_acc = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(cmd_ready), 64'd1);

        applyStimulus(8'd5, 8'd3, 3'b000, 1'b0);
        checkLatency();
        applyStimulus(8'd200, 8'd100, 3'b000, 1'b0);
        checkLatency();
        applyStimulus(8'b11001100, 8'b10101010, 3'b010, 1'b0);
        checkLatency();
        applyStimulus(8'b11001100, 8'b10101010, 3'b011, 1'b0);
        checkLatency();

        // Backpressure: result must hold and block new commands while res_ready is low
        waitIdle();
        res_ready = 1'b0;
        applyStimulus(8'b11110000, 8'd3, 3'b101, 1'b0);
        checkLatency();
        repeat (4) begin
            @(negedge clk);
            checkOutput("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            checkOutput("hold_res_valid", 64'(res_valid), 64'd1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("release_res_valid", 64'(res_valid), 64'd0);

        applyStimulus(8'd77, 8'd9, 3'b110, 1'b0);
        checkLatency();

        // Reset during EXEC drops the operation
        applyStimulus(8'd1, 8'd2, 3'b000, 1'b0);
        void'(expQ.pop_back());
        rst = 1'b1;
        #1 checkOutput("ready_in_reset", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        checkAllZero("mid_reset");
        accModel = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_mid_reset", 64'(cmd_ready), 64'd1);
        checkOutput("no_valid_after_mid_reset", 64'(res_valid), 64'd0);

        applyStimulus(8'd5, 8'd3, 3'b000, 1'b0);
        checkLatency();
        applyStimulus(8'd99, 8'd2, 3'b001, 1'b1);
        checkLatency();

        readyManual = 1'b0;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
            checkLatency();
        end

        n = 0;
        while ((expQ.size() != 0 || res_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
